// File: rtl/write_to_ddr3_pkg.sv
// Shared definitions for the DDR3 frame writer and its reader counterpart:
// FSM encoding, burst geometry and the last-burst index formula.
package write_to_ddr3_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BURST      = 2'd1,
        TEST_WRITE = 2'd2
    } wr_state_t;

    localparam int         BURST_LEN   = 4;
    localparam logic [2:0] SIZE_BURST  = 3'b100;
    localparam logic [2:0] SIZE_SINGLE = 3'b001;

    // Index of the last 4-beat burst in a frame; the reader uses the same formula.
    function automatic int max_count(input int width, input int height);
        return ((width * height) >> 2) - 1;
    endfunction

endpackage

// File: rtl/write_to_ddr3.sv
// Avalon-MM write master: drains a show-ahead frame FIFO into two alternating
// DDR3 frame buffers in 4-beat bursts and services single-beat test writes.
module write_to_ddr3
    import write_to_ddr3_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 1024
) (
    input  logic         ddr3_clk,
    input  logic         ddr3_reset_n,
    input  logic [127:0] fifo_data,
    input  logic [9:0]   fifo_level,
    output logic         fifo_rd,
    input  logic         ddr3_wr_buffer0_full,
    input  logic         ddr3_wr_buffer1_full,
    input  logic [25:0]  ddr3_buffer0_offset,
    input  logic [25:0]  ddr3_buffer1_offset,
    output logic         buffer0_done,
    output logic         buffer1_done,
    input  logic         test_wr,
    input  logic [31:0]  test_addr,
    input  logic [127:0] test_wr_data,
    output logic         wr_finish,
    input  logic         ddr3_avl_ready,
    output logic         ddr3_avl_burstbegin,
    output logic         ddr3_avl_write_req,
    output logic [2:0]   ddr3_avl_size,
    output logic [25:0]  ddr3_avl_addr,
    output logic [127:0] ddr3_avl_wdata,
    output logic [15:0]  ddr3_avl_be
);

    localparam int               MAX_COUNT  = max_count(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int               CNT_W      = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(MAX_COUNT);
    localparam int               BEAT_W     = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    wr_state_t          r_state, w_state_next;
    logic [CNT_W-1:0]   r_burst_count;
    logic [BEAT_W-1:0]  r_beat_count;
    logic               r_buffer_sel;
    logic               r_test_pending;
    logic [25:0]        r_test_addr;
    logic [127:0]       r_test_data;
    logic [25:0]        r_next_addr;
    logic [25:0]        r_avl_addr;
    logic [2:0]         r_avl_size;
    logic               r_buffer0_done, r_buffer1_done, r_wr_finish;

    logic               w_frame_ok, w_beat_accept, w_burst_end, w_test_accept;
    logic               w_sel_full;
    logic [25:0]        w_sel_offset;
    logic               w_test_addr_unused;

    assign w_test_addr_unused = ^test_addr[31:26];

    assign w_sel_full    = r_buffer_sel ? ddr3_wr_buffer1_full : ddr3_wr_buffer0_full;
    assign w_sel_offset  = r_buffer_sel ? ddr3_buffer1_offset : ddr3_buffer0_offset;
    assign w_frame_ok    = !w_sel_full && (fifo_level >= 10'(BURST_LEN));
    assign w_beat_accept = (r_state == BURST) && ddr3_avl_ready;
    assign w_burst_end   = w_beat_accept && (r_beat_count == LAST_BEAT);
    assign w_test_accept = (r_state == TEST_WRITE) && ddr3_avl_ready;

    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) r_state <= IDLE;
        else               r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        w_state_next        = r_state;
        ddr3_avl_write_req  = 1'b0;
        ddr3_avl_burstbegin = 1'b0;
        ddr3_avl_wdata      = fifo_data;
        fifo_rd             = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_test_pending)  w_state_next = TEST_WRITE;
                else if (w_frame_ok) w_state_next = BURST;
            end
            BURST: begin
                ddr3_avl_write_req  = 1'b1;
                ddr3_avl_burstbegin = (r_beat_count == '0);
                fifo_rd             = ddr3_avl_ready;
                if (w_burst_end) w_state_next = IDLE;
            end
            TEST_WRITE: begin
                ddr3_avl_write_req  = 1'b1;
                ddr3_avl_burstbegin = 1'b1;
                ddr3_avl_wdata      = r_test_data;
                if (ddr3_avl_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_burst_count  <= '0;
            r_beat_count   <= '0;
            r_buffer_sel   <= 1'b0;
            r_test_pending <= 1'b0;
            r_test_addr    <= '0;
            r_test_data    <= '0;
            r_next_addr    <= '0;
            r_avl_addr     <= '0;
            r_avl_size     <= '0;
            r_buffer0_done <= 1'b0;
            r_buffer1_done <= 1'b0;
            r_wr_finish    <= 1'b0;
        end else begin
            r_buffer0_done <= 1'b0;
            r_buffer1_done <= 1'b0;
            r_wr_finish    <= w_test_accept;

            // A fresh request wins over the clear so a back-to-back request is never lost.
            if (test_wr) begin
                r_test_pending <= 1'b1;
                r_test_addr    <= test_addr[25:0];
                r_test_data    <= test_wr_data;
            end else if (w_test_accept) begin
                r_test_pending <= 1'b0;
            end

            if (r_state == IDLE && r_test_pending) begin
                r_avl_addr <= r_test_addr;
                r_avl_size <= SIZE_SINGLE;
            end else if (r_state == IDLE && w_frame_ok) begin
                // The frame address lives in r_next_addr so a test write cannot derail it.
                r_avl_addr <= (r_burst_count == '0) ? w_sel_offset : r_next_addr;
                r_avl_size <= SIZE_BURST;
            end

            if (w_beat_accept)
                r_beat_count <= (r_beat_count == LAST_BEAT) ? '0 : r_beat_count + 1'b1;

            if (w_burst_end) begin
                if (r_burst_count == LAST_BURST) begin
                    r_buffer0_done <= !r_buffer_sel;
                    r_buffer1_done <= r_buffer_sel;
                    r_buffer_sel   <= !r_buffer_sel;
                    r_burst_count  <= '0;
                end else begin
                    r_burst_count  <= r_burst_count + 1'b1;
                    r_next_addr    <= r_avl_addr + 26'(BURST_LEN);
                end
            end
        end
    end

    assign ddr3_avl_addr = r_avl_addr;
    assign ddr3_avl_size = r_avl_size;
    assign ddr3_avl_be   = 16'hFFFF;
    assign buffer0_done  = r_buffer0_done;
    assign buffer1_done  = r_buffer1_done;
    assign wr_finish     = r_wr_finish;

endmodule

// File: tb/tb_write_to_ddr3.sv
// Directed bench for write_to_ddr3 with an 8x2 frame (four bursts per buffer):
// a vector table for IDLE decisions plus sequences for frames, stalls, test writes and reset.
module tb_write_to_ddr3;

    logic         ddr3_clk = 1'b0;
    logic         ddr3_reset_n;
    logic [127:0] fifo_data;
    logic [9:0]   fifo_level;
    logic         fifo_rd;
    logic         ddr3_wr_buffer0_full, ddr3_wr_buffer1_full;
    logic [25:0]  ddr3_buffer0_offset, ddr3_buffer1_offset;
    logic         buffer0_done, buffer1_done;
    logic         test_wr;
    logic [31:0]  test_addr;
    logic [127:0] test_wr_data;
    logic         wr_finish;
    logic         ddr3_avl_ready;
    logic         ddr3_avl_burstbegin, ddr3_avl_write_req;
    logic [2:0]   ddr3_avl_size;
    logic [25:0]  ddr3_avl_addr;
    logic [127:0] ddr3_avl_wdata;
    logic [15:0]  ddr3_avl_be;

    write_to_ddr3 #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2)) dut (
        .ddr3_clk(ddr3_clk), .ddr3_reset_n(ddr3_reset_n),
        .fifo_data(fifo_data), .fifo_level(fifo_level), .fifo_rd(fifo_rd),
        .ddr3_wr_buffer0_full(ddr3_wr_buffer0_full), .ddr3_wr_buffer1_full(ddr3_wr_buffer1_full),
        .ddr3_buffer0_offset(ddr3_buffer0_offset), .ddr3_buffer1_offset(ddr3_buffer1_offset),
        .buffer0_done(buffer0_done), .buffer1_done(buffer1_done),
        .test_wr(test_wr), .test_addr(test_addr), .test_wr_data(test_wr_data),
        .wr_finish(wr_finish), .ddr3_avl_ready(ddr3_avl_ready),
        .ddr3_avl_burstbegin(ddr3_avl_burstbegin), .ddr3_avl_write_req(ddr3_avl_write_req),
        .ddr3_avl_size(ddr3_avl_size), .ddr3_avl_addr(ddr3_avl_addr),
        .ddr3_avl_wdata(ddr3_avl_wdata), .ddr3_avl_be(ddr3_avl_be)
    );

    always #5 ddr3_clk = ~ddr3_clk;

    typedef struct {
        logic        full0;
        logic        full1;
        int          level;
        logic        test;
        logic        exp_wr;
        logic        exp_bb;
        logic [2:0]  exp_size;
        logic [25:0] exp_addr;
        string       name;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] fifo_q[$];
    int seq = 0;
    int cyc = 0;

    int           lg_n, pops, wr_seen, done0_cnt, done1_cnt, finish_cnt;
    int           done0_tick, done1_tick, finish_tick;
    logic [25:0]  lg_addr[64];
    logic [2:0]   lg_size[64];
    logic [127:0] lg_data[64];
    logic         lg_bb[64];
    int           lg_tick[64];

    localparam logic [127:0] TEST_DATA = {16{8'hA5}};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] word(input int n);
        return {32'hC0FFEE00, n[31:0], 32'h5A5A0000, ~n[31:0]};
    endfunction

    task automatic fifo_update();
        fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        fifo_level = (fifo_q.size() > 1023) ? 10'd1023 : 10'(fifo_q.size());
    endtask

    task automatic push(input int n);
        for (int k = 0; k < n; k++) begin
            fifo_q.push_back(word(seq));
            seq++;
        end
        fifo_update();
    endtask

    task automatic clear_log();
        lg_n = 0; pops = 0; wr_seen = 0;
        done0_cnt = 0; done1_cnt = 0; finish_cnt = 0;
        done0_tick = -1; done1_tick = -1; finish_tick = -1;
    endtask

    // One clock: sample outputs on the falling edge, then model the FIFO pop after the rising edge.
    task automatic tick();
        logic s_rd;
        logic [127:0] tmp;
        @(negedge ddr3_clk);
        cyc++;
        s_rd = fifo_rd;
        if (ddr3_avl_write_req) wr_seen++;
        if (ddr3_avl_write_req && ddr3_avl_ready && lg_n < 64) begin
            lg_addr[lg_n] = ddr3_avl_addr;
            lg_size[lg_n] = ddr3_avl_size;
            lg_data[lg_n] = ddr3_avl_wdata;
            lg_bb[lg_n]   = ddr3_avl_burstbegin;
            lg_tick[lg_n] = cyc;
            lg_n++;
        end
        if (s_rd) pops++;
        if (buffer0_done) begin done0_cnt++; done0_tick = cyc; end
        if (buffer1_done) begin done1_cnt++; done1_tick = cyc; end
        if (wr_finish)    begin finish_cnt++; finish_tick = cyc; end
        @(posedge ddr3_clk);
        #1;
        if (s_rd && fifo_q.size() > 0) tmp = fifo_q.pop_front();
        fifo_update();
    endtask

    task automatic do_reset();
        ddr3_reset_n         = 1'b0;
        test_wr              = 1'b0;
        test_addr            = '0;
        test_wr_data         = '0;
        ddr3_avl_ready       = 1'b0;
        ddr3_wr_buffer0_full = 1'b0;
        ddr3_wr_buffer1_full = 1'b0;
        ddr3_buffer0_offset  = 26'h100;
        ddr3_buffer1_offset  = 26'h200;
        fifo_q.delete();
        fifo_update();
        repeat (2) @(posedge ddr3_clk);
        #1 ddr3_reset_n = 1'b1;
        clear_log();
    endtask

    task automatic check_frame(input string tag, input logic [25:0] base, input int s0,
                               input int exp_d0, input int exp_d1);
        int bad_addr = 0;
        int bad_data = 0;
        int bad_size = 0;
        int bad_bb   = 0;
        int last     = (lg_n > 0) ? lg_tick[lg_n-1] : -10;
        check({tag, "_beats"}, lg_n, 16);
        for (int i = 0; i < lg_n; i++) begin
            if (lg_addr[i] !== base + 26'(4 * (i / 4))) bad_addr++;
            if (lg_data[i] !== word(s0 + i))             bad_data++;
            if (lg_size[i] !== 3'b100)                   bad_size++;
            if (lg_bb[i] !== (i % 4 == 0))               bad_bb++;
        end
        check({tag, "_addr_errs"}, bad_addr, 0);
        check({tag, "_data_errs"}, bad_data, 0);
        check({tag, "_size_errs"}, bad_size, 0);
        check({tag, "_bb_errs"}, bad_bb, 0);
        check({tag, "_pops"}, pops, 16);
        check({tag, "_done0"}, done0_cnt, exp_d0);
        check({tag, "_done1"}, done1_cnt, exp_d1);
        check({tag, "_done_cycle"}, (exp_d0 > 0) ? done0_tick : done1_tick, last + 1);
    endtask

    initial begin
        int s0;

        vecs[0] = '{1'b0, 1'b0, 4,    1'b0, 1'b1, 1'b1, 3'd4, 26'h100, "burst_basic"};
        vecs[1] = '{1'b0, 1'b0, 3,    1'b0, 1'b0, 1'b0, 3'd0, 26'h000, "starve3"};
        vecs[2] = '{1'b1, 1'b0, 8,    1'b0, 1'b0, 1'b0, 3'd0, 26'h000, "full0_wait"};
        vecs[3] = '{1'b0, 1'b1, 4,    1'b0, 1'b1, 1'b1, 3'd4, 26'h100, "full1_ignored"};
        vecs[4] = '{1'b0, 1'b0, 0,    1'b1, 1'b1, 1'b1, 3'd1, 26'h055, "test_only"};
        vecs[5] = '{1'b0, 1'b0, 8,    1'b1, 1'b1, 1'b1, 3'd4, 26'h100, "test_after_frame"};
        vecs[6] = '{1'b1, 1'b0, 8,    1'b1, 1'b1, 1'b1, 3'd1, 26'h055, "test_when_full"};
        vecs[7] = '{1'b0, 1'b0, 1023, 1'b0, 1'b1, 1'b1, 3'd4, 26'h100, "level_max"};

        // Reset state, observed while reset is held.
        ddr3_reset_n = 1'b0; test_wr = 1'b0; test_addr = '0; test_wr_data = '0;
        ddr3_avl_ready = 1'b1; ddr3_wr_buffer0_full = 1'b0; ddr3_wr_buffer1_full = 1'b0;
        ddr3_buffer0_offset = 26'h100; ddr3_buffer1_offset = 26'h200;
        push(8);
        repeat (2) @(posedge ddr3_clk);
        #1;
        check("reset_write_req", ddr3_avl_write_req, 1'b0);
        check("reset_burstbegin", ddr3_avl_burstbegin, 1'b0);
        check("reset_fifo_rd", fifo_rd, 1'b0);
        check("reset_addr", ddr3_avl_addr, 26'h0);
        check("reset_size", ddr3_avl_size, 3'd0);
        check("reset_pulses", {buffer0_done, buffer1_done, wr_finish}, 3'b000);
        check("be_all_ones", ddr3_avl_be, 16'hFFFF);

        // IDLE decision table: two cycles with ready low, then the request is held.
        for (int i = 0; i < NV; i++) begin
            do_reset();
            ddr3_wr_buffer0_full = vecs[i].full0;
            ddr3_wr_buffer1_full = vecs[i].full1;
            push(vecs[i].level);
            test_wr      = vecs[i].test;
            test_addr    = 32'hFC00_0055;
            test_wr_data = TEST_DATA;
            tick();
            test_wr = 1'b0;
            tick();
            check($sformatf("%s_wr", vecs[i].name), ddr3_avl_write_req, vecs[i].exp_wr);
            check($sformatf("%s_bb", vecs[i].name), ddr3_avl_burstbegin, vecs[i].exp_bb);
            check($sformatf("%s_size", vecs[i].name), ddr3_avl_size, vecs[i].exp_size);
            check($sformatf("%s_addr", vecs[i].name), ddr3_avl_addr, vecs[i].exp_addr);
            check($sformatf("%s_rd", vecs[i].name), fifo_rd, 1'b0);
        end

        // Frame 0 into buffer0 with ready held high.
        do_reset();
        s0 = seq;
        push(16);
        ddr3_avl_ready = 1'b1;
        repeat (30) tick();
        check_frame("frame0", 26'h100, s0, 1, 0);

        // Buffer1 still owned by the reader: no writes even with data waiting.
        clear_log();
        ddr3_wr_buffer1_full = 1'b1;
        s0 = seq;
        push(16);
        repeat (10) tick();
        check("full1_no_write", wr_seen, 0);
        check("full1_no_pop", pops, 0);

        // Release buffer1 and apply alternating backpressure.
        ddr3_wr_buffer1_full = 1'b0;
        for (int k = 0; k < 150 && done1_cnt == 0; k++) begin
            ddr3_avl_ready = (k % 2 == 0);
            tick();
        end
        check_frame("frame1", 26'h200, s0, 0, 1);

        // Buffers alternate: the next frame returns to buffer0 burst 0.
        clear_log();
        ddr3_avl_ready = 1'b1;
        s0 = seq;
        push(4);
        repeat (6) tick();
        check("frame2_beats", lg_n, 4);
        check("frame2_addr", lg_addr[0], 26'h100);

        // FIFO starvation: three words never start a burst; the fourth does next cycle.
        do_reset();
        push(3);
        ddr3_avl_ready = 1'b1;
        repeat (5) tick();
        check("starve_no_write", wr_seen, 0);
        push(1);
        check("starve_idle_now", ddr3_avl_write_req, 1'b0);
        tick();
        check("starve_wr_next", ddr3_avl_write_req, 1'b1);
        check("starve_bb_next", ddr3_avl_burstbegin, 1'b1);
        check("starve_addr_next", ddr3_avl_addr, 26'h100);

        // Test write requested on beat 1 of a burst.
        do_reset();
        s0 = seq;
        push(4);
        ddr3_avl_ready = 1'b1;
        tick();
        tick();
        test_wr      = 1'b1;
        test_addr    = 32'hFC00_0055;
        test_wr_data = TEST_DATA;
        tick();
        test_wr = 1'b0;
        repeat (12) tick();
        check("tw_beats", lg_n, 5);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tw_burst_addr%0d", i), lg_addr[i], 26'h100);
            check($sformatf("tw_burst_data%0d", i), lg_data[i], word(s0 + i));
        end
        check("tw_single_addr", lg_addr[4], 26'h055);
        check("tw_single_size", lg_size[4], 3'b001);
        check("tw_single_data", lg_data[4], TEST_DATA);
        check("tw_single_bb", lg_bb[4], 1'b1);
        check("tw_finish_count", finish_cnt, 1);
        check("tw_finish_cycle", finish_tick, lg_tick[4] + 1);
        check("tw_pops", pops, 4);

        // Reset asserted during beat 2 of a burst.
        do_reset();
        s0 = seq;
        push(8);
        ddr3_avl_ready = 1'b1;
        repeat (3) tick();
        check("rst_mid_beats_before", lg_n, 2);
        ddr3_reset_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {ddr3_avl_write_req, ddr3_avl_burstbegin, fifo_rd, buffer0_done, buffer1_done, wr_finish},
              6'b0);
        check("rst_mid_addr", ddr3_avl_addr, 26'h0);
        check("rst_mid_size", ddr3_avl_size, 3'd0);
        repeat (2) @(posedge ddr3_clk);
        #1 ddr3_reset_n = 1'b1;
        clear_log();
        repeat (8) tick();
        check("rst_after_beats", lg_n, 4);
        check("rst_after_addr", lg_addr[0], 26'h100);
        check("rst_after_data", lg_data[0], word(s0 + 2));
        check("rst_after_done0", done0_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
